l2_req_arbiter: RTL and testbench

Registered two-requester arbiter between the L1 instruction cache and L1 data cache miss ports and the single L2 cache port. It sequences one 256-bit line transaction at a time, gives the data cache priority by default, and promotes the instruction cache after a bounded number of consecutive data-cache grants so that neither requester starves. It also exposes the current owner and a saturating conflict counter for the performance unit.

---
 rtl/l2_req_arbiter.sv | 75 +++++++
 tb/tb_l2_req_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: registered I/D-cache to L2 arbiter, D-priority with bounded I starvation
module l2_req_arbiter #(
    parameter int WIDTH        = 256,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [WIDTH-1:0]  icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [WIDTH-1:0]  dcache_wdata,
    output logic [WIDTH-1:0]  dcache_rdata,
    output logic              dcache_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [WIDTH-1:0]  l2_wdata,
    input  logic [WIDTH-1:0]  l2_rdata,
    input  logic              l2_resp,
    output logic [1:0]        owner,
    output logic [15:0]       conflict_count
);
    typedef enum logic [1:0] {IDLE = 2'b00, SERVE_I = 2'b01, SERVE_D = 2'b10} state_t;
    state_t     state, state_nx;
    logic [3:0] d_streak, d_streak_nx;
    logic       d_req, decide, i_win, conflict, done;
    always_comb begin
        d_req       = dcache_read | dcache_write;
        decide      = (state == IDLE) && (icache_read | d_req);
        i_win       = icache_read && (!d_req || d_streak == 4'(STARVE_LIMIT));
        conflict    = decide && icache_read && d_req;
        done        = (state != IDLE) && l2_resp;
        state_nx    = decide ? (i_win ? SERVE_I : SERVE_D) : (done ? IDLE : state);
        // streak only grows while I is actually waiting behind D
        d_streak_nx = !decide ? d_streak :
                      (i_win || !icache_read) ? 4'd0 :
                      (d_streak == 4'(STARVE_LIMIT)) ? d_streak : d_streak + 4'd1;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            d_streak       <= 4'd0;
            conflict_count <= 16'd0;
            l2_read        <= 1'b0;
            l2_write       <= 1'b0;
            l2_address     <= '0;
            l2_wdata       <= '0;
        end else begin
            state    <= state_nx;
            d_streak <= d_streak_nx;
            if (conflict && conflict_count != 16'hFFFF)
                conflict_count <= conflict_count + 16'd1;
            if (decide) begin
                l2_read    <= i_win || !dcache_write;
                l2_write   <= !i_win && dcache_write;
                l2_address <= i_win ? icache_address : dcache_address;
                if (!i_win && dcache_write)
                    l2_wdata <= dcache_wdata;
            end else if (done) begin
                l2_read  <= 1'b0;
                l2_write <= 1'b0;
            end
        end
    end
    assign owner        = state;
    assign icache_resp  = (state == SERVE_I) && l2_resp;
    assign dcache_resp  = (state == SERVE_D) && l2_resp;
    assign icache_rdata = l2_rdata;
    assign dcache_rdata = l2_rdata;
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: directed checks of grant order, latency, starvation and reset for l2_req_arbiter
module tb_l2_req_arbiter;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         icache_read = 1'b0;
    logic [31:0]  icache_address = '0;
    logic [255:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read = 1'b0;
    logic         dcache_write = 1'b0;
    logic [31:0]  dcache_address = '0;
    logic [255:0] dcache_wdata = '0;
    logic [255:0] dcache_rdata;
    logic         dcache_resp;
    logic         l2_read, l2_write;
    logic [31:0]  l2_address;
    logic [255:0] l2_wdata;
    logic [255:0] l2_rdata = '0;
    logic         l2_resp = 1'b0;
    logic [1:0]   owner;
    logic [15:0]  conflict_count;
    int           vectors = 0;
    int           errors = 0;
    logic [1:0]   exp_owner [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

    l2_req_arbiter #(.WIDTH(256), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .owner(owner), .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        icache_read  = 1'b1;
        dcache_write = 1'b1;
        tick; tick;
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        chk("rst_owner", owner, 0);
        chk("rst_conflict", conflict_count, 0);
        chk("rst_l2_address", l2_address, 0);
        reset_n        = 1'b1;
        dcache_write   = 1'b0;
        icache_address = 32'h0000_1000;
        tick;
        chk("i_grant_read", l2_read, 1);
        chk("i_grant_write", l2_write, 0);
        chk("i_grant_addr", l2_address, 32'h0000_1000);
        chk("i_grant_owner", owner, 2'b01);
        repeat (4) tick;
        l2_resp  = 1'b1;
        l2_rdata = {32{8'hA5}};
        #1;
        chk("i_resp", icache_resp, 1);
        chk("i_rdata", icache_rdata, {32{8'hA5}});
        chk("i_resp_d_quiet", dcache_resp, 0);
        tick;
        l2_resp     = 1'b0;
        icache_read = 1'b0;
        #1;
        chk("i_done_owner", owner, 0);
        chk("i_done_read", l2_read, 0);
        chk("i_done_resp", icache_resp, 0);

        icache_read    = 1'b1;
        icache_address = 32'h0000_3000;
        dcache_write   = 1'b1;
        dcache_address = 32'h0000_2000;
        dcache_wdata   = 256'h1234;
        tick;
        chk("sim_owner", owner, 2'b10);
        chk("sim_write", l2_write, 1);
        chk("sim_read", l2_read, 0);
        chk("sim_addr", l2_address, 32'h0000_2000);
        chk("sim_wdata", l2_wdata, 256'h1234);
        chk("sim_conflict", conflict_count, 1);
        tick;
        l2_resp = 1'b1;
        #1;
        chk("sim_d_resp", dcache_resp, 1);
        chk("sim_i_quiet", icache_resp, 0);
        tick;
        l2_resp      = 1'b0;
        dcache_write = 1'b0;
        #1;
        chk("sim_gap_owner", owner, 0);
        tick;
        chk("sim_i_owner", owner, 2'b01);
        chk("sim_i_read", l2_read, 1);
        chk("sim_i_addr", l2_address, 32'h0000_3000);
        chk("sim_i_conflict", conflict_count, 1);
        l2_resp = 1'b1;
        #1;
        chk("sim_i_resp", icache_resp, 1);
        tick;
        l2_resp = 1'b0;

        dcache_read    = 1'b1;
        dcache_address = 32'h0000_5000;
        icache_address = 32'h0000_4000;
        for (int g = 0; g < 6; g++) begin
            tick;
            chk($sformatf("starve_owner%0d", g), owner, exp_owner[g]);
            chk($sformatf("starve_addr%0d", g), l2_address,
                exp_owner[g] == 2'b01 ? 32'h0000_4000 : 32'h0000_5000);
            l2_resp = 1'b1;
            tick;
            l2_resp = 1'b0;
        end
        chk("starve_conflict", conflict_count, 7);

        icache_read    = 1'b0;
        dcache_write   = 1'b1;
        dcache_address = 32'h0000_6000;
        dcache_wdata   = 256'hBEEF;
        tick;
        chk("rw_write", l2_write, 1);
        chk("rw_read", l2_read, 0);
        chk("rw_wdata", l2_wdata, 256'hBEEF);
        chk("rw_owner", owner, 2'b10);
        chk("rw_conflict", conflict_count, 7);
        tick;
        reset_n = 1'b0;
        l2_resp = 1'b1;
        #1;
        chk("mid_rst_write", l2_write, 0);
        chk("mid_rst_owner", owner, 0);
        chk("mid_rst_d_resp", dcache_resp, 0);
        chk("mid_rst_conflict", conflict_count, 0);
        chk("mid_rst_wdata", l2_wdata, 0);
        tick;
        l2_resp      = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        reset_n      = 1'b1;
        tick;
        l2_resp = 1'b1;
        #1;
        chk("stray_d_resp", dcache_resp, 0);
        chk("stray_i_resp", icache_resp, 0);
        tick;
        l2_resp = 1'b0;
        chk("stray_owner", owner, 0);
        chk("stray_read", l2_read, 0);
        chk("stray_write", l2_write, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
